// File: rtl/maxpool_2x2.sv
// 2x2 stride-2 max pooling over a raster stream of NUM_CH parallel channels, optional ReLU.
// Result registered one cycle after the accepting edge; valid-only, no backpressure.
module maxpool_2x2 #(
    parameter int IN_W   = 28,
    parameter int IN_H   = 28,
    parameter int NUM_CH = 6,
    parameter int DW     = 16,
    parameter int RELU   = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_feature_valid,
    input  logic signed [DW-1:0] i_features [0:NUM_CH-1],
    input  logic                 i_last_feature,
    output logic                 o_feature_valid,
    output logic signed [DW-1:0] o_features [0:NUM_CH-1],
    output logic                 o_last_feature,
    output logic                 o_frame_err
);
    localparam int CW = $clog2(IN_W);
    localparam int RW = $clog2(IN_H);

    typedef enum logic {ROW_EVEN = 1'b0, ROW_ODD = 1'b1} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        col_q, col_d;
    logic [RW-1:0]        row_q, row_d;
    logic [CW-2:0]        pair_idx;
    logic signed [DW-1:0] hold_q   [0:NUM_CH-1];
    logic signed [DW-1:0] rowbuf_q [0:IN_W/2-1][0:NUM_CH-1];
    logic signed [DW-1:0] hmax     [0:NUM_CH-1];
    logic signed [DW-1:0] pooled   [0:NUM_CH-1];
    logic                 col_wrap, row_wrap, at_final;
    logic                 early_last, pair_vld, emit;

    function automatic logic signed [DW-1:0] smax(input logic signed [DW-1:0] a,
                                                   input logic signed [DW-1:0] b);
        return (a >= b) ? a : b;
    endfunction

    always_comb begin
        pair_idx   = col_q[CW-1:1];
        col_wrap   = (col_q == CW'(IN_W - 1));
        row_wrap   = (row_q == RW'(IN_H - 1));
        at_final   = col_wrap && row_wrap;
        early_last = i_feature_valid && i_last_feature && !at_final;
        pair_vld   = i_feature_valid && col_q[0] && !early_last;
        emit       = pair_vld && (state_q == ROW_ODD);

        col_d = col_q;
        row_d = row_q;
        if (i_feature_valid) begin
            if (i_last_feature) begin
                col_d = '0;
                row_d = '0;
            end else if (col_wrap) begin
                col_d = '0;
                row_d = row_wrap ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
        // Row parity is the FSM: it only moves on column wrap or a frame-ending sample.
        state_d = row_d[0] ? ROW_ODD : ROW_EVEN;

        for (int ch = 0; ch < NUM_CH; ch++) begin
            hmax[ch]   = smax(hold_q[ch], i_features[ch]);
            pooled[ch] = smax(rowbuf_q[pair_idx][ch], hmax[ch]);
            if (RELU != 0 && pooled[ch] < 0) begin
                pooled[ch] = '0;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q         <= ROW_EVEN;
            col_q           <= '0;
            row_q           <= '0;
            o_feature_valid <= 1'b0;
            o_last_feature  <= 1'b0;
            o_frame_err     <= 1'b0;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                hold_q[ch]     <= '0;
                o_features[ch] <= '0;
            end
        end else begin
            state_q         <= state_d;
            col_q           <= col_d;
            row_q           <= row_d;
            o_feature_valid <= emit;
            o_last_feature  <= emit && at_final;
            o_frame_err     <= early_last;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                if (i_feature_valid && !col_q[0] && !early_last) begin
                    hold_q[ch] <= i_features[ch];
                end
                if (emit) begin
                    o_features[ch] <= pooled[ch];
                end
            end
        end
    end

    // Every entry is rewritten in an even row before the odd row reads it, so no reset.
    always_ff @(posedge i_clk) begin
        if (pair_vld && (state_q == ROW_EVEN)) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                rowbuf_q[pair_idx][ch] <= hmax[ch];
            end
        end
    end

endmodule

// File: tb/tb_maxpool_2x2.sv
// Bench for maxpool_2x2: two instances (ReLU on/off) fed the same stream, checked against
// a frame-array reference model plus table-driven and hand-written frame sequences.
module tb_maxpool_2x2;
    localparam int W  = 28;
    localparam int H  = 28;
    localparam int NC = 6;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst;
    logic in_vld, in_last;
    logic signed [DW-1:0] in_f [0:NC-1];
    logic v1, l1, e1, v0, l0, e0;
    logic signed [DW-1:0] f1 [0:NC-1];
    logic signed [DW-1:0] f0 [0:NC-1];

    always #5 clk = ~clk;

    maxpool_2x2 #(.IN_W(W), .IN_H(H), .NUM_CH(NC), .DW(DW), .RELU(1)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_feature_valid(in_vld), .i_features(in_f),
        .i_last_feature(in_last), .o_feature_valid(v1), .o_features(f1),
        .o_last_feature(l1), .o_frame_err(e1));

    maxpool_2x2 #(.IN_W(W), .IN_H(H), .NUM_CH(NC), .DW(DW), .RELU(0)) dut0 (
        .i_clk(clk), .i_rst(rst), .i_feature_valid(in_vld), .i_features(in_f),
        .i_last_feature(in_last), .o_feature_valid(v0), .o_features(f0),
        .o_last_feature(l0), .o_frame_err(e0));

    typedef struct {
        int   cyc;
        logic last;
        int   f [0:NC-1];
    } out_t;

    typedef struct {
        int mode;
        int val;
        int gapped;
        int idle_pct;
        int last_at_end;
        int exp_cnt;
        int has_first;
        int first_r1;
        int first_r0;
    } vec_t;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;
    int   stray_last = 0;
    int   pix [0:H-1][0:W-1][0:NC-1];
    int   drv_cyc [0:H-1][0:W-1];
    out_t q1[$];
    out_t q0[$];
    int   qe1[$];
    int   qe0[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        out_t o;
        if (v1) begin
            o.cyc = cyc; o.last = l1;
            for (int i = 0; i < NC; i++) o.f[i] = f1[i];
            q1.push_back(o);
        end
        if (v0) begin
            o.cyc = cyc; o.last = l0;
            for (int i = 0; i < NC; i++) o.f[i] = f0[i];
            q0.push_back(o);
        end
        if (e1) qe1.push_back(cyc);
        if (e0) qe0.push_back(cyc);
        if ((l1 && !v1) || (l0 && !v0)) stray_last++;
    end

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int pool_exp(input int r2, input int c2, input int ch, input bit relu);
        int m;
        m = pix[2*r2][2*c2][ch];
        if (pix[2*r2][2*c2+1][ch]   > m) m = pix[2*r2][2*c2+1][ch];
        if (pix[2*r2+1][2*c2][ch]   > m) m = pix[2*r2+1][2*c2][ch];
        if (pix[2*r2+1][2*c2+1][ch] > m) m = pix[2*r2+1][2*c2+1][ch];
        if (relu && m < 0) m = 0;
        return m;
    endfunction

    task automatic idle_cycle();
        @(negedge clk);
        in_vld  = 1'b0;
        in_last = 1'($urandom);
        for (int ch = 0; ch < NC; ch++) in_f[ch] = 16'($urandom);
    endtask

    // Drives raster samples (0,0)..(stop_r,stop_c); mode 0 const, 1 ramp, 2 random, 3 tie-heavy.
    task automatic run_frame(input int mode, input int val, input int gapped, input int idle_pct,
                             input int stop_r, input int stop_c, input int last_at_stop);
        int stop_idx;
        logic signed [DW-1:0] s;
        stop_idx = stop_r * W + stop_c;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (r * W + c <= stop_idx) begin
                    for (int ch = 0; ch < NC; ch++) begin
                        case (mode)
                            0: pix[r][c][ch] = val;
                            1: pix[r][c][ch] = (ch == 0) ? r * W + c : (ch == 5) ? -(r * W + c) : val;
                            2: begin s = 16'($urandom); pix[r][c][ch] = s; end
                            default: pix[r][c][ch] = int'($urandom_range(0, 6)) - 3;
                        endcase
                    end
                    while (idle_pct > 0 && int'($urandom_range(0, 99)) < idle_pct) idle_cycle();
                    @(negedge clk);
                    drv_cyc[r][c] = cyc;
                    in_vld  = 1'b1;
                    in_last = (r * W + c == stop_idx) && (last_at_stop != 0);
                    for (int ch = 0; ch < NC; ch++) in_f[ch] = 16'(pix[r][c][ch]);
                    if (gapped != 0) idle_cycle();
                end
            end
        end
        idle_cycle();
        repeat (2) @(negedge clk);
    endtask

    task automatic check_outputs(input string tag, input int stop_r, input int stop_c,
                                 input bit early, input bit ramp);
        int   stop_idx, exp_n, idx, r2, c2, qs;
        out_t o;
        stop_idx = stop_r * W + stop_c;
        exp_n = 0;
        for (int k = 0; k < (H/2) * (W/2); k++) begin
            idx = (2 * (k / (W/2)) + 1) * W + 2 * (k % (W/2)) + 1;
            if (idx < stop_idx || (idx == stop_idx && !early)) exp_n++;
        end
        chk({tag, "_count_relu1"}, q1.size(), exp_n);
        chk({tag, "_count_relu0"}, q0.size(), exp_n);
        for (int d = 0; d < 2; d++) begin
            qs = (d == 1) ? q1.size() : q0.size();
            for (int k = 0; k < exp_n; k++) begin
                if (k < qs) begin
                    o   = (d == 1) ? q1[k] : q0[k];
                    r2  = k / (W/2);
                    c2  = k % (W/2);
                    idx = (2 * r2 + 1) * W + 2 * c2 + 1;
                    chk({tag, "_latency"}, o.cyc, drv_cyc[2*r2+1][2*c2+1] + 1);
                    chk({tag, "_last"}, o.last, (idx == H * W - 1) ? 1 : 0);
                    for (int ch = 0; ch < NC; ch++)
                        chk({tag, "_value"}, o.f[ch], pool_exp(r2, c2, ch, d == 1));
                    if (ramp && d == 0) begin
                        chk({tag, "_ramp_ch0"}, o.f[0], (2*r2+1) * W + 2*c2 + 1);
                        chk({tag, "_ramp_ch5_norelu"}, o.f[5], -(2*r2*W + 2*c2));
                    end else if (ramp) begin
                        chk({tag, "_ramp_ch5_relu"}, o.f[5], 0);
                    end
                end
            end
        end
        chk({tag, "_err_count_relu1"}, qe1.size(), early ? 1 : 0);
        chk({tag, "_err_count_relu0"}, qe0.size(), early ? 1 : 0);
        if (early && qe1.size() > 0) chk({tag, "_err_timing"}, qe1[0], drv_cyc[stop_r][stop_c] + 1);
        q1.delete(); q0.delete(); qe1.delete(); qe0.delete();
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_valid"}, {v1, v0}, 0);
        chk({tag, "_last"}, {l1, l0}, 0);
        chk({tag, "_err"}, {e1, e0}, 0);
        for (int ch = 0; ch < NC; ch++) begin
            chk({tag, "_feat_relu1"}, f1[ch], 0);
            chk({tag, "_feat_relu0"}, f0[ch], 0);
        end
    endtask

    initial begin
        vec_t tbl [0:5];
        tbl[0] = '{0,  40, 0,  0, 1, 196, 1, 40,  40};
        tbl[1] = '{1,  -9, 0,  0, 1, 196, 1,  0,  -9};
        tbl[2] = '{0,  40, 1,  0, 1, 196, 1, 40,  40};
        tbl[3] = '{0,  -7, 0,  0, 0, 196, 1,  0,  -7};
        tbl[4] = '{2,   0, 0, 30, 1, 196, 0,  0,   0};
        tbl[5] = '{3,   0, 0, 10, 1, 196, 0,  0,   0};

        rst = 1'b1; in_vld = 1'b0; in_last = 1'b0;
        for (int ch = 0; ch < NC; ch++) in_f[ch] = '0;
        repeat (3) @(negedge clk);
        check_reset("reset");
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_frame(tbl[i].mode, tbl[i].val, tbl[i].gapped, tbl[i].idle_pct,
                      H-1, W-1, tbl[i].last_at_end);
            chk("tbl_count", q1.size(), tbl[i].exp_cnt);
            if (tbl[i].has_first != 0 && q1.size() > 0 && q0.size() > 0) begin
                chk("tbl_first_relu1", q1[0].f[1], tbl[i].first_r1);
                chk("tbl_first_relu0", q0[0].f[1], tbl[i].first_r0);
            end
            check_outputs("frame", H-1, W-1, 1'b0, tbl[i].mode == 1);
        end

        // Early frame end at (3,5), then a clean frame of 41.
        run_frame(2, 0, 0, 0, 3, 5, 1);
        check_outputs("early", 3, 5, 1'b1, 1'b0);
        run_frame(0, 41, 0, 0, H-1, W-1, 1);
        if (q1.size() > 0) chk("after_early_first", q1[0].f[0], 41);
        check_outputs("after_early", H-1, W-1, 1'b0, 1'b0);

        // Reset mid-frame at (10,11), then a full frame of -7.
        run_frame(2, 0, 0, 0, 10, 11, 0);
        check_outputs("pre_reset", 10, 11, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset("mid_reset");
        rst = 1'b0;
        run_frame(0, -7, 0, 0, H-1, W-1, 1);
        if (q0.size() > 0) chk("after_reset_first_relu0", q0[0].f[3], -7);
        if (q1.size() > 0) chk("after_reset_first_relu1", q1[0].f[3], 0);
        check_outputs("after_reset", H-1, W-1, 1'b0, 1'b0);

        chk("stray_last", stray_last, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
